// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target for the memory stage.
// One load/store in flight, WAIT_CYCLES wait states, RV32 byte/half/word lane
// steering with sign/zero extension, error response for bad accesses.
// Optional build macro: DMEM_MISALIGN_ERR_EN makes misaligned half/word
// accesses fault; without it the low address bits are forced aligned.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    // Access source: live request when accessing straight from IDLE, latched copy otherwise
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [1:0]    acc_size;
    logic          acc_uns;
    logic          do_access;
    logic          below_base;
    logic [31:0]   offset;
    logic [31:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          fault;
    logic [1:0]    lane;
    logic [31:0]   rword;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wmerge;
    logic          mem_we;

    // Address decode, fault detection, load extraction and store lane steering
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
        end

        // Borrow out of the subtraction flags addresses below the base
        {below_base, offset} = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
        word_idx = offset >> 2;
        mem_idx  = word_idx[AW-1:0];
        lane     = acc_addr[1:0];

        fault = (acc_size == 2'b11) || below_base || (word_idx >= DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
        if ((acc_size == 2'b01 && lane[0]) || (acc_size == 2'b10 && lane != 2'b00)) begin
            fault = 1'b1;
        end
`endif

        rword = mem_q[mem_idx];
        bsel  = rword[{lane, 3'b000} +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];

        load_data = '0;
        be        = '0;
        wmerge    = '0;
        unique case (acc_size)
            2'b00: begin
                load_data = {{24{bsel[7] & ~acc_uns}}, bsel};
                be        = 4'b0001 << lane;
                wmerge    = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                load_data = {{16{hsel[15] & ~acc_uns}}, hsel};
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wmerge    = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                load_data = rword;
                be        = 4'b1111;
                wmerge    = acc_wdata;
            end
            default: begin
                load_data = '0;
                be        = '0;
                wmerge    = '0;
            end
        endcase

        do_access = !reset &&
                    (((state_q == WAIT) && (cnt_q == '0)) ||
                     ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)));
        mem_we    = do_access && acc_write && !fault;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            rdata_d = (fault || acc_write) ? '0 : load_data;
            err_d   = fault;
        end
    end

    // Control and response registers; aborts any transaction on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: byte-enabled commit on the edge entering RESP, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wmerge[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's memory stage, on the target side of a valid/ready request/response handshake.
- Accepts one load or store at a time.
- Models a configurable number of wait states.
- Performs RV32 byte, halfword and word lane steering with sign or zero extension on loads.
- Returns read data or an error flag on a separate response channel.
- Replaces the zero-latency combinational data memory once the pipeline gains stall support.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the storage array.
WAIT_CYCLES, 2, wait states between request acceptance and the access; 0 is legal.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  initiator presents a request.
req_ready  out  1  responder can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0 (funct3[2]).
resp_valid  out  1  response is available.
resp_ready  in  1  initiator accepts the response.
resp_rdata  out  32  load result; 0 for stores and errors.
resp_err  out  1  access faulted; nothing was written.

Behaviour:
- Reset (async assert) forces:
  - state = IDLE
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0
  - wait counter = 0
  - array contents are not reset.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch write, addr, wdata, size and unsigned.
  - Go to WAIT with counter = WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES = 0.
- WAIT:
  - req_ready = 0; the counter decrements each cycle.
  - When the counter is 0, perform the access and go to RESP.
- Access:
  - Happens on the edge entering RESP: store bytes commit, and resp_rdata/resp_err are registered.
- RESP:
  - resp_valid = 1 and req_ready = 0; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE.
  - resp_valid drops the next cycle; resp_rdata and resp_err keep their last values.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Throughput: at most one request per WAIT_CYCLES+2 cycles, because IDLE lasts at least one cycle.
- Word index = (addr - BASE_ADDR) >> 2; lane = addr[1:0].
- Stores:
  - byte: lane enable 1<<lane, using wdata[7:0].
  - half: lanes {lane[1],0} and {lane[1],1}, using wdata[15:0].
  - word: all four lanes.
- Loads:
  - Select the addressed byte or half.
  - Extend to 32 bits per req_unsigned; a word load ignores req_unsigned.
- Error cases (resp_err = 1, resp_rdata = 0, no write):
  - req_size = 11;
  - addr < BASE_ADDR;
  - word index >= DEPTH_WORDS.
- Request inputs are ignored outside IDLE; the latched copy is used throughout.
- Reset asserted in WAIT or RESP:
  - The transaction is aborted and no response is issued.
  - A store not yet committed (reset before the RESP entry edge) is lost.
  - A committed store remains in the array.
- resp_ready asserted outside RESP is ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, is an error.
  - Result: resp_err = 1, resp_rdata = 0, no write.
  - Latency is unchanged.
- Undefined:
  - No misalignment error; the low address bits are forced aligned.
  - Half ignores addr[0]; word ignores addr[1:0].

Test Plan:
- Word round trip (WAIT_CYCLES = 2): store word 0xDEADBEEF @0x10, then load word @0x10 → resp_valid 3 cycles after each acceptance; rdata = 0xDEADBEEF, err = 0.
- Byte lanes and extension: after the previous store, store byte 0x80 @0x11.
  - Signed byte load @0x11 → 0xFFFFFF80.
  - Unsigned byte load @0x11 → 0x00000080.
  - Word load @0x10 → 0xDEAD80EF.
- Half store and load: store half 0x1234 @0x12; signed half load @0x12 → 0x00001234; word load @0x10 → 0x123480EF.
- Out of range: load @ (BASE_ADDR + 4*DEPTH_WORDS) → err = 1, rdata = 0; req_size = 11 → err = 1, and a following read shows the array unchanged.
- Backpressure and reset:
  - Hold resp_ready = 0 for 5 cycles in RESP → resp_valid and rdata stay stable and req_ready stays 0.
  - Assert reset during WAIT of a store → no response is issued, and a later load returns the old data.
- Misalignment: word load @0x12.
  - With DMEM_MISALIGN_ERR_EN → err = 1.
  - Without it → returns the word @0x10, err = 0.
